// File: rtl/cpu_controller.sv
// cpu_controller: Moore control FSM for the 16-bit CPU datapath.
// Sequences fetch / PC increment / decode / execute and drives every
// datapath control from the current state and IR. Controls are registered:
// each edge loads the control word belonging to the state being entered, so
// the outputs are clean flops that change only on clock edges.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        loadir,
    output logic        asel,
    output logic        bsel,
    output logic        msel,
    output logic        mwrite,
    output logic [3:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        incp,
    output logic        execb,
    output logic        tsel,
    output logic [2:0]  cond,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        halted
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPDPC, S_DECODE,
        S_WIMM, S_GETA, S_GETB, S_EXEC, S_WRD,
        S_ADDR, S_MEM1, S_MEM2, S_GETBD, S_MEMW,
        S_BR, S_BL, S_BXJ, S_BLXJ, S_HALT
    } state_t;

    typedef struct packed {
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       loadir;
        logic       asel;
        logic       bsel;
        logic       msel;
        logic       mwrite;
        logic [3:0] vsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       incp;
        logic       execb;
        logic       tsel;
        logic [2:0] cond;
        logic       halted;
    } ctl_t;

    // Write-back selects (one-hot)
    localparam logic [3:0] VSEL_MDATA = 4'b1000;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_C     = 4'b0001;

    // {opcode, op} encodings
    localparam logic [4:0] I_MOVI = 5'b110_10;
    localparam logic [4:0] I_MOVR = 5'b110_00;
    localparam logic [4:0] I_ADD  = 5'b101_00;
    localparam logic [4:0] I_CMP  = 5'b101_01;
    localparam logic [4:0] I_AND  = 5'b101_10;
    localparam logic [4:0] I_MVN  = 5'b101_11;
    localparam logic [4:0] I_LDR  = 5'b011_00;
    localparam logic [4:0] I_STR  = 5'b100_00;
    localparam logic [4:0] I_B    = 5'b001_00;
    localparam logic [4:0] I_BL   = 5'b010_11;
    localparam logic [4:0] I_BX   = 5'b010_00;
    localparam logic [4:0] I_BLX  = 5'b010_10;

    state_t     state, nxt;
    ctl_t       ctl_q;
    logic [4:0] opc;

    assign opc    = IR[15:11];
    assign sximm5 = {{11{IR[4]}}, IR[4:0]};
    assign sximm8 = {{8{IR[7]}}, IR[7:0]};

    // Control word for a given state; fields default to 0.
    function automatic ctl_t ctl_for(input state_t s, input logic [15:0] ir);
        ctl_t c;
        c = '0;
        case (s)
            S_IF1:    c.msel = 1'b0;
            S_IF2:    begin c.msel = 1'b0; c.loadir = 1'b1; end
            S_UPDPC:  c.incp = 1'b1;
            S_WIMM:   begin c.writenum = ir[10:8]; c.vsel = VSEL_IMM8; c.write = 1'b1; end
            S_GETA: begin
                // BX/BLX take their target register from the Rd field
                c.readnum = (ir[15:13] == 3'b010) ? ir[7:5] : ir[10:8];
                c.loada   = 1'b1;
            end
            S_GETB:   begin c.readnum = ir[2:0]; c.loadb = 1'b1; end
            S_EXEC: begin
                c.shift  = ir[4:3];
                c.alu_op = ir[12:11];
                if (ir[15:11] == I_CMP) c.loads = 1'b1;
                else                    c.loadc = 1'b1;
                // MOV Rd,Rm passes B through an ADD with A forced to zero
                if (ir[15:11] == I_MOVR) c.asel = 1'b1;
            end
            S_WRD:    begin c.writenum = ir[7:5]; c.vsel = VSEL_C; c.write = 1'b1; end
            S_ADDR:   begin c.bsel = 1'b1; c.alu_op = 2'b00; c.loadc = 1'b1; end
            S_MEM1:   c.msel = 1'b1;
            S_MEM2: begin
                c.msel = 1'b1; c.writenum = ir[7:5]; c.vsel = VSEL_MDATA; c.write = 1'b1;
            end
            S_GETBD:  begin c.readnum = ir[7:5]; c.loadb = 1'b1; end
            S_MEMW:   begin c.msel = 1'b1; c.mwrite = 1'b1; end
            S_BR:     begin c.execb = 1'b1; c.cond = ir[10:8]; c.tsel = 1'b1; end
            S_BL: begin
                // link and branch in the same cycle; R7 gets the incremented PC
                c.writenum = 3'd7; c.vsel = VSEL_PC; c.write = 1'b1;
                c.execb = 1'b1; c.cond = 3'b000; c.tsel = 1'b1;
            end
            S_BXJ:    begin c.execb = 1'b1; c.cond = 3'b000; c.tsel = 1'b0; end
            S_BLXJ: begin
                c.writenum = 3'd7; c.vsel = VSEL_PC; c.write = 1'b1;
                c.execb = 1'b1; c.cond = 3'b000; c.tsel = 1'b0;
            end
            S_HALT:   c.halted = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Next-state sequencing; every instruction path returns to IF1
    always_comb begin
        nxt = state;
        case (state)
            S_RST:    nxt = S_IF1;
            S_IF1:    nxt = S_IF2;
            S_IF2:    nxt = S_UPDPC;
            S_UPDPC:  nxt = S_DECODE;
            S_DECODE: begin
                case (opc)
                    I_MOVI:                         nxt = S_WIMM;
                    I_MOVR, I_MVN:                  nxt = S_GETB;
                    I_ADD, I_AND, I_CMP:            nxt = S_GETA;
                    I_LDR, I_STR:                   nxt = S_GETA;
                    I_BX, I_BLX:                    nxt = S_GETA;
                    I_B:                            nxt = S_BR;
                    I_BL:                           nxt = S_BL;
                    default:                        nxt = S_HALT;
                endcase
            end
            S_GETA: begin
                if (opc == I_LDR || opc == I_STR) nxt = S_ADDR;
                else if (opc == I_BX)             nxt = S_BXJ;
                else if (opc == I_BLX)            nxt = S_BLXJ;
                else                              nxt = S_GETB;
            end
            S_GETB:   nxt = S_EXEC;
            S_EXEC:   nxt = (opc == I_CMP) ? S_IF1 : S_WRD;
            S_WRD:    nxt = S_IF1;
            S_WIMM:   nxt = S_IF1;
            S_ADDR:   nxt = (opc == I_LDR) ? S_MEM1 : S_GETBD;
            S_MEM1:   nxt = S_MEM2;
            S_MEM2:   nxt = S_IF1;
            S_GETBD:  nxt = S_MEMW;
            S_MEMW:   nxt = S_IF1;
            S_BR, S_BL, S_BXJ, S_BLXJ: nxt = S_IF1;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_HALT;
        endcase
    end

    // State and registered control word; reset wins over every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RST;
            ctl_q <= '0;
        end else begin
            state <= nxt;
            ctl_q <= ctl_for(nxt, IR);
        end
    end

    assign writenum = ctl_q.writenum;
    assign readnum  = ctl_q.readnum;
    assign write    = ctl_q.write;
    assign loada    = ctl_q.loada;
    assign loadb    = ctl_q.loadb;
    assign loadc    = ctl_q.loadc;
    assign loads    = ctl_q.loads;
    assign loadir   = ctl_q.loadir;
    assign asel     = ctl_q.asel;
    assign bsel     = ctl_q.bsel;
    assign msel     = ctl_q.msel;
    assign mwrite   = ctl_q.mwrite;
    assign vsel     = ctl_q.vsel;
    assign shift    = ctl_q.shift;
    assign ALUop    = ctl_q.alu_op;
    assign incp     = ctl_q.incp;
    assign execb    = ctl_q.execb;
    assign tsel     = ctl_q.tsel;
    assign cond     = ctl_q.cond;
    assign halted   = ctl_q.halted;

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Moore-style control FSM for the 16-bit CPU: the other end of the datapath's control interface. It sequences fetch, PC increment, decode and execute for every instruction. For each state it drives the datapath's register-file, ALU, memory, IR and PC-select controls, and it sign-extends the immediates held in IR. The datapath returns only IR, so every decision here is made from IR alone.

## Interface
- No parameters. Instruction fields: opcode = IR[15:13], op = IR[12:11], Rn/cond = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- clk  in  1  rising-edge clock; one clock only.
- reset  in  1  synchronous, active-high.
- IR  in  16  instruction register from the datapath.
- writenum, readnum  out  3  register-file write and read select.
- write, loada, loadb, loadc, loads, loadir  out  1  register and file load enables.
- asel  out  1  1 selects 16'b0 as ALU A operand.
- bsel  out  1  1 selects sximm5 as ALU B operand.
- msel  out  1  memory address select: 0 = PC, 1 = C[7:0].
- mwrite  out  1  RAM write enable.
- vsel  out  4  one-hot write-back select: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C. Value is 0000 when write=0.
- shift  out  2  shifter control; 00 except in EXEC.
- ALUop  out  2  00 ADD, 01 SUB/CMP, 10 AND, 11 NOT B.
- incp, execb, tsel  out  1  PC control: incp → PC+1; execb → branch evaluation; tsel: 1 = PC+sximm8, 0 = A[7:0].
- cond  out  3  branch condition; 000 = always.
- sximm5, sximm8  out  16  combinational sign extension of IR[4:0] and IR[7:0].
- halted  out  1  high in HALT.

## Operation
- States: RST, IF1, IF2, UPDPC, DECODE, WIMM, GETA, GETB, EXEC, WRD, ADDR, MEM1, MEM2, GETBD, MEMW, BR, BL, BXJ, BLXJ, HALT.
- All outputs are decoded from state and IR only. Any control not listed for a state is 0.
- RST: all controls 0; next state IF1. The datapath clears PC itself while reset is high.
- Fetch:
  - IF1: msel=0.
  - IF2: msel=0, loadir=1.
  - UPDPC: incp=1.
  - DECODE: no controls; branches on {opcode, op}.
- MOV Rn,#imm8 (110/10): WIMM asserts writenum=Rn, vsel=0100, write=1 → IF1.
- MOV Rd,Rm{,sh} (110/00): GETB → EXEC with asel=1, ALUop=00 → WRD → IF1.
- ADD/AND (101/00, 101/10): GETA → GETB → EXEC → WRD → IF1.
  - MVN (101/11) skips GETA.
  - CMP (101/01) runs GETA → GETB → EXEC with loads=1, loadc=0 → IF1.
- State controls:
  - GETA: readnum=Rn, loada=1. For BX/BLX, readnum=Rd instead.
  - GETB: readnum=Rm, loadb=1.
  - EXEC: shift=sh, ALUop=op, loadc=1.
  - WRD: writenum=Rd, vsel=0001, write=1.
- LDR (011/00): GETA → ADDR → MEM1 → MEM2 → IF1.
  - ADDR: bsel=1, ALUop=00, loadc=1.
  - MEM1: msel=1.
  - MEM2: msel=1, writenum=Rd, vsel=1000, write=1.
- STR (100/00): GETA → ADDR → GETBD → MEMW → IF1.
  - GETBD: readnum=Rd, loadb=1.
  - MEMW: msel=1, mwrite=1.
- B (001/00): BR asserts execb=1, cond=IR[10:8], tsel=1 → IF1. Target is incremented PC + sximm8[7:0], mod 256.
- BL (010/11): BL asserts writenum=7, vsel=0010, write=1, execb=1, cond=000, tsel=1, all in one cycle → IF1. R7 receives the already-incremented PC.
- BX (010/00): GETA → BXJ with execb=1, cond=000, tsel=0 → IF1.
- BLX (010/10): GETA → BLXJ, which is BXJ plus writenum=7, vsel=0010, write=1 → IF1.
- HALT (111/xx) and any undefined {opcode, op}: go to HALT and stay there, halted=1, all controls 0, until reset.

## Timing
- reset has priority over every state: the next edge after reset=1 enters RST, including mid-instruction and mid-MEMW. mwrite is 0 in RST.
- First IF1 occurs one cycle after reset deasserts.
- Cycles from IF1 back to the next IF1:
  - MOV imm, B, BL: 5
  - BX, BLX: 6
  - MOV reg, MVN, CMP: 7
  - ADD, AND, LDR, STR: 8
- IR is stable from IF2+1 until the next IF2, so decode outputs never glitch within an instruction.
- Exactly one of incp/execb is high in any cycle, or neither. PC holds otherwise.
- A register written in state N is readable by GETA/GETB from state N+1.

## Test plan
- Reset mid-ADD (assert in EXEC) → RST next cycle with all outputs 0; IF1 one cycle after release.
- IR=16'hD0FB (MOV R0,#-5) → sximm8=16'hFFFB; WIMM asserts writenum=0, vsel=0100, write=1; IF1 recurs 5 cycles later.
- IR=16'hA148 (ADD R2,R1,R0,LSL#1) → GETA readnum=1, GETB readnum=0, EXEC shift=01 ALUop=00, WRD writenum=2.
- IR=16'h6245 (LDR R2,[R2,#5]) → ADDR bsel=1 with sximm5=16'h0005; MEM2 asserts msel=1, vsel=1000, writenum=2.
- IR=16'h5F04 (BL #4) → one cycle with write=1, writenum=7, vsel=0010, execb=1, tsel=1, cond=000.
- IR=16'hE000 → halted=1 indefinitely with mwrite=0 and write=0; reset returns to RST.
